// File: rtl/serial_sub_pkg.sv
`default_nettype none
// =============================================================================
// Module  : serial_sub_pkg
// Brief   : Shared types and constants for the bit-serial subtractor.
// Revision: 1.0 - initial release
// =============================================================================
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Bit counter width; clamped to 1 so a degenerate WIDTH still elaborates.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// =============================================================================
// Module  : full_subtractor
// Brief   : 1-bit combinational subtractor cell, d = a - b - bin.
// Revision: 1.0 - initial release
// =============================================================================
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// =============================================================================
// Module  : serial_subtractor
// Brief   : Bit-serial WIDTH-bit A - B, LSB first, Start/Busy/Done handshake.
//           Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf_o.
// Revision: 1.0 - initial release
// =============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             busy_o,
    output logic             done_o
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int            CW         = cnt_width(WIDTH);
    localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic             w_d;
    logic             w_bout;

    full_subtractor u_fs (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .bin_i  (br_q),
        .d_o    (w_d),
        .bout_o (w_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Result fills from the MSB end so bit 0 lands at [0] after WIDTH shifts.
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d  = {w_d, res_q[WIDTH-1:1]};
                br_d   = w_bout;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == C_LAST_BIT) begin
                    diff_d  = {w_d, res_q[WIDTH-1:1]};
                    bout_d  = w_bout;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign diff_o = diff_q;
    assign bout_o = bout_q;
    assign busy_o = (state_q == S_RUN);
    assign done_o = (state_q == S_DONE);

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    // The final serial bit is the result MSB, so overflow resolves on the last RUN cycle.
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if ((state_q != S_RUN) && start_i) begin
            a_msb_d = a_i[WIDTH-1];
            b_msb_d = b_i[WIDTH-1];
        end
        if ((state_q == S_RUN) && (cnt_q == C_LAST_BIT)) begin
            ovf_d = (a_msb_q ^ b_msb_q) & (w_d ^ a_msb_q);
        end
    end

    assign ovf_o = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// =============================================================================
// Module  : tb_serial_subtractor
// Brief   : Self-checking bench: cycle-level reference model plus directed vectors.
// Revision: 1.0 - initial release
// =============================================================================
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .diff_o  (diff),
        .bout_o  (bout),
        .busy_o  (busy),
        .done_o  (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf_o   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int to_signed(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? int'(v) - (1 << WIDTH) : int'(v);
    endfunction

    // Reference model: an operation accepted at one edge completes WIDTH edges later.
    logic             m_busy, m_done, m_bout, m_ovf;
    logic [WIDTH-1:0] m_diff;
    logic             p_bout, p_ovf;
    logic [WIDTH-1:0] p_diff;
    int               m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_ovf  <= 1'b0;
            m_left <= 0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_diff <= p_diff;
                m_bout <= p_bout;
                m_ovf  <= p_ovf;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (start) begin
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_left <= WIDTH;
            p_diff <= WIDTH'((int'(a) - int'(b)) & ((1 << WIDTH) - 1));
            p_bout <= (a < b);
            p_ovf  <= ((to_signed(a) - to_signed(b)) > ((1 << (WIDTH-1)) - 1)) ||
                      ((to_signed(a) - to_signed(b)) < -(1 << (WIDTH-1)));
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("busy", int'(busy), int'(m_busy));
        check("done", int'(done), int'(m_done));
        check("diff", int'(diff), int'(m_diff));
        check("bout", int'(bout), int'(m_bout));
        check("busy_done_excl", int'(busy & done), 0);
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", int'(ovf), int'(m_ovf));
`endif
    end

    // Starts from an idle cycle, waits (bounded) for Done and checks the latency.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        int edges;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        start = 1'b0;
        a     = 4'($urandom);
        b     = 4'($urandom);
        edges = 0;
        while (!done && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: no Done within 20 cycles for a=%0d b=%0d", av, bv);
        end else begin
            check("latency", edges, WIDTH);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_diff", int'(diff), 0);
        check("rst_bout", int'(bout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;

        do_op(4'd9, 4'd3);
        check("lit_9m3_diff", int'(diff), 6);
        check("lit_9m3_bout", int'(bout), 0);
        do_op(4'd3, 4'd9);
        check("lit_3m9_diff", int'(diff), 10);
        check("lit_3m9_bout", int'(bout), 1);
        do_op(4'd15, 4'd15);
        check("lit_15m15_diff", int'(diff), 0);
        check("lit_15m15_bout", int'(bout), 0);
        do_op(4'd0, 4'd1);
        check("lit_0m1_diff", int'(diff), 15);
        check("lit_0m1_bout", int'(bout), 1);
`ifdef SERIAL_SUB_OVF_EN
        do_op(4'd7, 4'd8);
        check("lit_7m8_diff", int'(diff), 15);
        check("lit_7m8_ovf", int'(ovf), 1);
        do_op(4'd5, 4'd2);
        check("lit_5m2_ovf", int'(ovf), 0);
`endif

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_op(4'(i), 4'(j));
            end
        end

        // Reset during the second RUN cycle discards the operation.
        do_op(4'd0, 4'd1);
        @(negedge clk);
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_diff", int'(diff), 0);
        check("midrst_bout", int'(bout), 0);
        repeat (8) begin
            @(negedge clk);
            check("midrst_no_done", int'(done), 0);
        end
        do_op(4'd5, 4'd2);
        check("post_rst_diff", int'(diff), 3);

        // Start held high: mid-operation operand changes are ignored, DONE chains.
        @(negedge clk);
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd3;
        repeat (4) begin
            @(negedge clk);
            a = 4'($urandom);
            b = 4'($urandom);
        end
        @(negedge clk);
        check("hold1_done", int'(done), 1);
        check("hold1_diff", int'(diff), 6);
        check("hold1_bout", int'(bout), 0);
        a = 4'd12;
        b = 4'd5;
        repeat (4) begin
            @(negedge clk);
            check("hold_gap_no_done", int'(done), 0);
            a = 4'($urandom);
            b = 4'($urandom);
        end
        @(negedge clk);
        check("hold2_done", int'(done), 1);
        check("hold2_diff", int'(diff), 7);
        check("hold2_bout", int'(bout), 0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_end_diff", int'(diff), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing A − B, LSB first, one bit per clock, with a Start/Busy/Done handshake. It is the inverse-operation companion to the team's multi-cycle serial adder and shares its clocking and stimulus style, so the existing loop-over-all-operands bench flow applies unchanged. Results are registered and held until the next accepted Start.

## Interface
- WIDTH, default 4: operand and result width in bits; legal range ≥ 2.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high; priority over every other input.
- Start  in  1  request; sampled only in IDLE or DONE.
- A  in  WIDTH  minuend, captured on an accepted Start.
- B  in  WIDTH  subtrahend, captured on an accepted Start.
- Diff  out  WIDTH  registered A − B mod 2^WIDTH.
- Bout  out  1  registered final borrow (1 when A < B unsigned).
- Busy  out  1  high while in RUN.
- Done  out  1  one-cycle pulse; Diff and Bout are valid from this cycle onward.
- Ovf  out  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, Start=1 → capture A and B into shift registers, clear borrow and bit counter, go to RUN.
- IDLE, Start=0 → stay in IDLE.
- RUN, per cycle, with a = A_sh[0], b = B_sh[0], br = borrow:
  - d = a ^ b ^ br
  - br' = (~a & b) | (~(a ^ b) & br)
  - shift d into the result register from the MSB end
  - shift A_sh and B_sh right by one
  - increment the counter.
- RUN, on the cycle processing bit WIDTH−1 → load Diff from the completed result, load Bout = br', go to DONE.
- DONE → Done=1 for this single cycle. If Start=1, accept it exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Start while in RUN is ignored; the captured operands are not disturbed.
- A and B are don't-care except on the accepting edge.
- Diff and Bout hold their values through IDLE and RUN until the next completion.
- Reset (any state, including mid-RUN) → IDLE; Diff=0, Bout=0, Busy=0, Done=0, Ovf=0; counter, borrow and shift registers cleared. The partial operation is discarded.
- Reset values of all outputs are 0.

## Timing
- Edge E0 samples Start=1: Busy rises after E0.
- Edges E1..E_WIDTH each process one bit.
- Diff, Bout and Done update at E_WIDTH. Done is high from E_WIDTH to E_WIDTH+1.
- Latency: WIDTH clock edges from the accepting edge to Done; WIDTH=4 gives Done 4 cycles after Start.
- Throughput: one result per WIDTH+1 cycles when Start is held high.
- Busy and Done are never high in the same cycle.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - Ovf port exists.
  - Ovf = (A[MSB] ≠ B[MSB]) & (Diff[MSB] ≠ A[MSB]), using the captured operand MSBs.
  - Registered together with Diff at E_WIDTH; same reset and hold rules as Diff.
- SERIAL_SUB_OVF_EN undefined: no Ovf port, no MSB capture flops.

## Structure
- Package serial_sub_pkg:
  - state enum typedef (IDLE, RUN, DONE)
  - default WIDTH constant
  - counter-width localparam function, $clog2(WIDTH).
- Sub-module full_subtractor: 1-bit combinational cell, inputs a, b, bin; outputs d, bout. Instantiated once in the serial datapath.

## Test plan
- WIDTH=4, A=9, B=3, Start pulse → Done 4 cycles later; Diff=6, Bout=0.
- A=3, B=9 → Diff=4'b1010, Bout=1. A=15, B=15 → Diff=0, Bout=0. A=0, B=1 → Diff=15, Bout=1.
- Exhaustive i,j ∈ [0,15]: Diff == (i−j) mod 16 and Bout == (i<j) on every Done pulse.
- A=9, B=3 started, Reset asserted at cycle 2 of RUN → next cycle IDLE, all outputs 0, Done never pulses. A following Start with A=5, B=2 → Diff=3.
- Start held high through RUN with A/B changed mid-operation → the original operands complete. Start high during DONE → a new operation begins; Done pulses every 5 cycles.
- With SERIAL_SUB_OVF_EN: A=7, B=8 → Diff=4'b1111, Ovf=1. A=5, B=2 → Ovf=0.
